// File: rtl/addn_serial_pkg.sv
// ============================================================================
// Module : addn_pkg
// Brief  : Shared types and helpers for the addn_serial multi-cycle adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Slice-counter width; a single-slice adder still needs a 1-bit counter.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/addn_serial_slice_add.sv
// ============================================================================
// Module : slice_add
// Brief  : W-bit combinational add with carry-out and carry into the MSB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module slice_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);

    logic [W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
    assign sum    = w_full[W-1:0];
    assign c_out  = w_full[W];
    // The MSB sum bit is a^b^cin, so the incoming carry falls out of it.
    assign c_msb  = a[W-1] ^ b[W-1] ^ w_full[W-1];

endmodule

`default_nettype wire

// File: rtl/addn_serial.sv
// ============================================================================
// Module : addn_serial
// Brief  : Serial N-bit add/subtract, W bits per cycle, valid/ready on both
//          sides. Define ADDN_SERIAL_FLAGS_EN to add zero/negative flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addn_serial
    import addn_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
`ifdef ADDN_SERIAL_FLAGS_EN
    output logic         busy,
    output logic         zero,
    output logic         negative
`else
    output logic         busy
`endif
);

    localparam int K  = N / W;
    localparam int CW = cnt_width(K);
    localparam logic [N-1:0] C_SLICE_MASK = N'({W{1'b1}});

    generate
        if ((N % W) != 0) begin : g_bad_width
            $error("addn_serial: N must be a multiple of W");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_carry;
    logic [CW-1:0]   r_k;
    logic [N-1:0]    r_sum;
    logic            r_c_out;
    logic            r_ovf;

    logic            w_i_ready;
    logic            w_accept;
    logic            w_last;
    int              w_base;
    logic [W-1:0]    w_a_slice;
    logic [W-1:0]    w_b_slice;
    logic [W-1:0]    w_slc_sum;
    logic            w_slc_cout;
    logic            w_slc_cmsb;
    logic [N-1:0]    w_sum_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_i_ready = 1'b1;
                if (i_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // A consumer accept frees the block in the same cycle.
                w_i_ready = o_ready;
                if (o_ready) w_state_nxt = i_valid ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept  = i_valid & w_i_ready;
    assign w_last    = (r_k == CW'(K - 1));
    assign w_base    = int'(r_k) * W;
    assign w_a_slice = W'(r_a >> w_base);
    assign w_b_slice = W'(r_b >> w_base);

    slice_add #(
        .W (W)
    ) u_slice_add (
        .a     (w_a_slice),
        .b     (w_b_slice),
        .c_in  (r_carry),
        .sum   (w_slc_sum),
        .c_out (w_slc_cout),
        .c_msb (w_slc_cmsb)
    );

    assign w_sum_next = (r_sum & ~(C_SLICE_MASK << w_base))
                      | (N'(w_slc_sum) << w_base);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b once and seed the carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | c_in;
            r_k     <= '0;
        end else if (r_state == S_RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_slc_cout;
            r_k     <= r_k + CW'(1);
            if (w_last) begin
                r_c_out <= w_slc_cout;
                r_ovf   <= w_slc_cmsb ^ w_slc_cout;
            end
        end
    end

`ifdef ADDN_SERIAL_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (!w_accept && (r_state == S_RUN) && w_last) begin
            r_zero <= (w_sum_next == '0);
            r_neg  <= w_sum_next[N-1];
        end
    end

    assign zero     = r_zero;
    assign negative = r_neg;
`endif

    assign i_ready  = w_i_ready;
    assign o_valid  = (r_state == S_DONE);
    assign busy     = (r_state == S_RUN);
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_addn_serial.sv
// ============================================================================
// Module : tb_addn_serial
// Brief  : Self-checking bench for addn_serial (N=32, W=8) against an
//          arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_addn_serial;

    localparam int N = 32;
    localparam int W = 8;
    localparam int K = N / W;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          c_in;
    logic          sub;
    logic          o_valid;
    logic          o_ready;
    logic [N-1:0]  sum;
    logic          c_out;
    logic          overflow;
    logic          busy;
`ifdef ADDN_SERIAL_FLAGS_EN
    logic          zero;
    logic          negative;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [N-1:0]  e_sum;
    logic          e_c;
    logic          e_ov;

    addn_serial #(
        .N (N),
        .W (W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
`ifdef ADDN_SERIAL_FLAGS_EN
        .busy     (busy),
        .zero     (zero),
        .negative (negative)
`else
        .busy     (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Reference: signed/unsigned integer arithmetic on the whole operands.
    task automatic model(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic tcin, input logic tsub);
        longint sa, sb, res;
        longint unsigned ua, ub, ures;
        sa = longint'($signed(ta));
        sb = longint'($signed(tb_v));
        ua = longint'(ta);
        ub = longint'(tb_v);
        if (tsub) begin
            res   = sa - sb;
            ures  = ua - ub;
            e_c   = (ua >= ub);
        end else begin
            res   = sa + sb + longint'(tcin);
            ures  = ua + ub + longint'(tcin);
            e_c   = ures[N];
        end
        e_sum = ures[N-1:0];
        e_ov  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    endtask

    task automatic start(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic tcin, input logic tsub, input logic chain);
        int guard = 0;
        @(negedge clk);
        a = ta; b = tb_v; c_in = tcin; sub = tsub; i_valid = 1'b1;
        if (chain) o_ready = 1'b1;
        #1;
        if (chain) chk("chain_i_ready", i_ready, 1);
        while (!i_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_in_time", guard < 20, 1);
        model(ta, tb_v, tcin, tsub);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("o_valid_after_accept", o_valid, 0);
    endtask

    // Edges are counted with the accepting edge as the first.
    task automatic wait_result(input string tag);
        int edges = 1;
        while (!o_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_latency"}, edges, K + 1);
        chk({tag, "_sum"}, sum, e_sum);
        chk({tag, "_c_out"}, c_out, e_c);
        chk({tag, "_ovf"}, overflow, e_ov);
`ifdef ADDN_SERIAL_FLAGS_EN
        chk({tag, "_zero"}, zero, e_sum == 0);
        chk({tag, "_neg"}, negative, e_sum[N-1]);
`endif
    endtask

    task automatic consume();
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        chk("o_valid_after_consume", o_valid, 0);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] ta,
                          input logic [N-1:0] tb_v, input logic tcin, input logic tsub);
        start(ta, tb_v, tcin, tsub, 1'b0);
        wait_result(tag);
        consume();
    endtask

    initial begin
        rst = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_i_ready", i_ready, 1);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        run_op("inc_byte", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sub_neg",  32'd5, 32'd7, 1'b1, 1'b1);
        run_op("sub_pos",  32'd7, 32'd5, 1'b0, 1'b1);
        run_op("cin",      32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("neg_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

        // Backpressure: result must hold while the consumer stalls.
        start(32'h1000_0001, 32'h2000_0002, 1'b0, 1'b0, 1'b0);
        wait_result("bp");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_o_valid", o_valid, 1);
            chk("bp_sum", sum, e_sum);
            chk("bp_c_out", c_out, e_c);
            chk("bp_i_ready", i_ready, 0);
        end
        start(32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        wait_result("chain");
        chk("chain_value", sum, 32'd7);
        consume();

        // Reset in the middle of a run.
        start(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_i_ready", i_ready, 1);
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_c_out", c_out, 0);
        chk("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", $urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/addn_serial.md
Name: addn_serial

Overview:
- Multi-cycle, parametrised successor to the team's combinational ripple adder.
- Adds or subtracts two N-bit operands W bits per cycle, holding the slice carry in a register between cycles.
- Uses a valid/ready handshake on both input and output.
- Sits in datapaths where area matters more than latency, such as a shared ALU back-end or a multi-word accumulator.

Parameters:
N  32  operand/result width in bits
W  8   slice width added per cycle; N % W == 0 is required (elaboration error otherwise)
K  N/W derived localparam, not overridable: slices per operation

Ports:
clk       input   1  clock, all state updates on rising edge
rst       input   1  asynchronous, active-low reset
i_valid   input   1  operands valid
i_ready   output  1  block can accept operands this cycle
a         input   N  operand A
b         input   N  operand B
c_in      input   1  carry in (ignored when sub=1)
sub       input   1  0: a+b+c_in; 1: a-b (a + ~b + 1)
o_valid   output  1  result valid
o_ready   input   1  consumer accepts result
sum       output  N  result
c_out     output  1  final carry; for sub, 1 = no borrow
overflow  output  1  two's-complement signed overflow
busy      output  1  high in RUN

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-low.
- Reset (rst low, any state, including mid-operation):
  - State goes to IDLE and any in-flight operation is discarded.
  - o_valid, sum, c_out, overflow, busy, slice counter and carry register all clear to 0.
  - i_ready reads 1 while in reset.
- States are IDLE, RUN and DONE.
- IDLE:
  - i_ready=1.
  - On i_valid&&i_ready: latch a; latch b, or ~b when sub=1; set carry reg = sub ? 1 : c_in; clear counter k=0; go to RUN.
- RUN:
  - i_ready=0, busy=1.
  - Each cycle: {carry, sum[k*W +: W]} <= a_slice + b_slice + carry, then k <= k+1.
  - On slice k==K-1: c_out <= slice carry-out; overflow <= carry into bit N-1 XOR carry-out of bit N-1; go to DONE.
- DONE:
  - o_valid=1; sum, c_out and overflow are held stable until o_valid&&o_ready.
  - On the output handshake: go to IDLE.
  - i_ready = o_ready in DONE. If i_valid is also high in that cycle, the new operands are accepted and the state goes directly to RUN; o_valid drops the following cycle.
- Latency and throughput:
  - o_valid rises exactly K+1 rising edges after the accepting edge (K RUN cycles).
  - Back-to-back throughput is one result per K+1 cycles.
- Corner case K=1 (W=N): one RUN cycle.
- The sum register is updated slice-by-slice during RUN. Its value is defined only while o_valid=1.
- Operands changing after acceptance have no effect.
- No X propagation: all registers are reset.

Optional Feature:
- Macro: ADDN_SERIAL_FLAGS_EN.
- Defined: adds output ports zero (1: sum==0) and negative (1: sum[N-1]). Both are registered in the final RUN cycle, reset to 0, and held with sum in DONE.
- Undefined: these ports do not exist and no flag logic is generated.

Decomposition:
- Package addn_pkg holds:
  - the state enum typedef (S_IDLE, S_RUN, S_DONE);
  - a function or constant for the counter width, $clog2(K) with a minimum of 1.
- One natural sub-module, slice_add: W-bit combinational add with inputs a, b, c_in and outputs sum, c_out, c_msb (carry into the MSB, used for overflow).

Test Plan:
All scenarios use N=32, W=8 (K=4).
1. 0x000000FF + 0x00000001, c_in=0 -> sum=0x00000100, c_out=0, overflow=0; o_valid exactly 5 edges after accept.
2. 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, c_out=1, overflow=0. This exercises carry through all 4 slices.
3. 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1, c_out=0. With the flag macro: negative=1, zero=0.
4. Subtraction:
   - sub=1, a=5, b=7, c_in=1 (ignored) -> sum=0xFFFFFFFE, c_out=0, overflow=0.
   - sub=1, a=7, b=5 -> sum=2, c_out=1.
5. Backpressure:
   - Hold o_ready=0 for 6 cycles in DONE -> o_valid, sum and c_out stable, i_ready=0 throughout.
   - Then raise o_ready with i_valid=1 (operands 3+4) -> accepted the same cycle, next result 7 after K+1 edges.
6. Reset mid-operation:
   - Assert rst low after 2 RUN cycles -> all outputs 0 and i_ready=1 during reset.
   - After release, 0x12345678 + 0x11111111 -> sum=0x23456789.
